vec_execute_unit: RTL and testbench

- Execute stage directly downstream of the vector decode stage.
- Consumes the two 16-lane register operands and the extended immediate, and applies one lane-wise ALU operation.
- Processes PAR lanes per cycle, so a full vector takes LANES/PAR cycles, with a valid/ready handshake on both sides.
- Forwards the destination register and write enable with the result towards memory/writeback.

---
 rtl/vec_execute_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_vec_execute_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_execute_unit.sv
// rtl/vec_execute_unit.sv - lane-wise vector ALU execute stage, PAR lanes per cycle.
// Optional VEXEC_SAT_EN: signed saturating add/sub plus sat_flag output.
module vec_execute_unit #(
  parameter int N     = 20,
  parameter int LANES = 16,
  parameter int PAR   = 4
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*N-1:0]   rd1,
  input  logic [LANES*N-1:0]   rd2,
  input  logic [LANES*N-1:0]   ExtImm,
  input  logic                 ALUSrc,
  input  logic [2:0]           ALUControl,
  input  logic [3:0]           wa3,
  input  logic                 RegWrite,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*N-1:0]   result,
  output logic [3:0]           wa3_out,
  output logic                 RegWrite_out,
  output logic                 busy
`ifdef VEXEC_SAT_EN
  ,
  output logic                 sat_flag
`endif
);

  localparam int STEPS = LANES / PAR;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
`ifdef VEXEC_SAT_EN
  localparam int LW    = N + 1;
`else
  localparam int LW    = N;
`endif

  if (LANES % PAR != 0) begin : g_bad_par
    $error("vec_execute_unit: LANES must be a multiple of PAR");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LANES*N-1:0] a_q, a_d;
  logic [LANES*N-1:0] b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [LANES*N-1:0] result_q, result_d;
  logic [3:0]         wa3_q, wa3_d;
  logic               rw_q, rw_d;
`ifdef VEXEC_SAT_EN
  logic               sat_q, sat_d;
  logic               chunk_sat;
`endif

  logic [LANES*N-1:0] res_upd;
  logic [LW-1:0]      lane_o [PAR];
  int                 base;

  // Returns the lane result; with saturation enabled the MSB is the saturate flag.
  function automatic logic [LW-1:0] lane_alu(input logic [2:0] op,
                                              input logic [N-1:0] a,
                                              input logic [N-1:0] b);
    logic [N-1:0] r;
`ifdef VEXEC_SAT_EN
    logic         s;
    logic [N:0]   ext;
    s   = 1'b0;
    ext = '0;
`endif
    r = '0;
    case (op)
`ifdef VEXEC_SAT_EN
      3'b000, 3'b001: begin
        ext = (op == 3'b000) ? ({a[N-1], a} + {b[N-1], b})
                             : ({a[N-1], a} - {b[N-1], b});
        if (ext[N] != ext[N-1]) begin
          s = 1'b1;
          r = ext[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
          r = ext[N-1:0];
        end
      end
`else
      3'b000:  r = a + b;
      3'b001:  r = a - b;
`endif
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      3'b101:  r = a << b[3:0];
      3'b110:  r = a >> b[3:0];
      default: r = b;
    endcase
`ifdef VEXEC_SAT_EN
    return {s, r};
`else
    return r;
`endif
  endfunction

  // Chunk datapath: lanes [cnt*PAR +: PAR] merged into the held result.
  always_comb begin
    res_upd = result_q;
    base    = int'(cnt_q) * PAR;
`ifdef VEXEC_SAT_EN
    chunk_sat = 1'b0;
`endif
    for (int p = 0; p < PAR; p++) begin
      lane_o[p] = lane_alu(op_q, a_q[(base + p)*N +: N], b_q[(base + p)*N +: N]);
      res_upd[(base + p)*N +: N] = lane_o[p][N-1:0];
`ifdef VEXEC_SAT_EN
      chunk_sat = chunk_sat | lane_o[p][N];
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    wa3_d    = wa3_q;
    rw_d     = rw_q;
`ifdef VEXEC_SAT_EN
    sat_d    = sat_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          a_d     = rd1;
          b_d     = ALUSrc ? ExtImm : rd2;
          op_d    = ALUControl;
          wa3_d   = wa3;
          rw_d    = RegWrite;
          cnt_d   = '0;
`ifdef VEXEC_SAT_EN
          sat_d   = 1'b0;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
          rw_d    = 1'b0;
          cnt_d   = '0;
`ifdef VEXEC_SAT_EN
          sat_d   = 1'b0;
`endif
        end else begin
          result_d = res_upd;
`ifdef VEXEC_SAT_EN
          sat_d    = sat_q | chunk_sat;
`endif
          if (cnt_q == CW'(STEPS - 1)) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        // Flush takes priority over a simultaneous downstream accept.
        if (flush) begin
          state_d = S_IDLE;
          rw_d    = 1'b0;
`ifdef VEXEC_SAT_EN
          sat_d   = 1'b0;
`endif
        end else if (out_ready) begin
          state_d = S_IDLE;
`ifdef VEXEC_SAT_EN
          sat_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      wa3_q    <= '0;
      rw_q     <= 1'b0;
`ifdef VEXEC_SAT_EN
      sat_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      wa3_q    <= wa3_d;
      rw_q     <= rw_d;
`ifdef VEXEC_SAT_EN
      sat_q    <= sat_d;
`endif
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign result       = result_q;
  assign wa3_out      = wa3_q;
  assign RegWrite_out = rw_q;
`ifdef VEXEC_SAT_EN
  assign sat_flag     = sat_q & out_valid;
`endif

endmodule

// File: tb/tb_vec_execute_unit.sv
// tb/tb_vec_execute_unit.sv - scoreboard bench for vec_execute_unit.
module tb_vec_execute_unit;
  localparam int N     = 20;
  localparam int LANES = 16;
  localparam int PAR   = 4;
  localparam int W     = LANES * N;

  logic         clk = 1'b0;
  logic         RST, flush, in_valid, in_ready;
  logic [W-1:0] rd1, rd2, ExtImm;
  logic         ALUSrc;
  logic [2:0]   ALUControl;
  logic [3:0]   wa3;
  logic         RegWrite;
  logic         out_valid, out_ready;
  logic [W-1:0] result;
  logic [3:0]   wa3_out;
  logic         RegWrite_out, busy;
`ifdef VEXEC_SAT_EN
  logic         sat_flag;
`endif

  vec_execute_unit #(.N(N), .LANES(LANES), .PAR(PAR)) dut (
    .clk(clk), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .rd1(rd1), .rd2(rd2), .ExtImm(ExtImm), .ALUSrc(ALUSrc), .ALUControl(ALUControl),
    .wa3(wa3), .RegWrite(RegWrite), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .wa3_out(wa3_out), .RegWrite_out(RegWrite_out), .busy(busy)
`ifdef VEXEC_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   wa3;
    logic         rw;
    logic         sat;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_vec = 0;
  int           n_err = 0;
  int           ov_count = 0;
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_res;
  logic         rand_ready = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: per-lane integer arithmetic reduced modulo 2^N.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] imm, input logic src,
                                 input logic [2:0] op, input logic [3:0] wa, input logic rw);
    exp_t   e;
    longint x, y, r, m;
`ifdef VEXEC_SAT_EN
    longint sx, sy;
`endif
    m     = longint'(1) << N;
    e.res = '0;
    e.wa3 = wa;
    e.rw  = rw;
    e.sat = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      x = longint'(a[i*N +: N]);
      y = src ? longint'(imm[i*N +: N]) : longint'(b[i*N +: N]);
      case (op)
        3'd0:    r = x + y;
        3'd1:    r = x - y;
        3'd2:    r = x & y;
        3'd3:    r = x | y;
        3'd4:    r = x ^ y;
        3'd5:    r = x << (y % 16);
        3'd6:    r = x >> (y % 16);
        default: r = y;
      endcase
`ifdef VEXEC_SAT_EN
      if (op <= 3'd1) begin
        sx = (x >= m / 2) ? x - m : x;
        sy = (y >= m / 2) ? y - m : y;
        r  = (op == 3'd0) ? sx + sy : sx - sy;
        if (r > m / 2 - 1) begin
          r = m / 2 - 1;
          e.sat = 1'b1;
        end else if (r < -(m / 2)) begin
          r = -(m / 2);
          e.sat = 1'b1;
        end
      end
`endif
      r = ((r % m) + m) % m;
      e.res[i*N +: N] = r[N-1:0];
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_vec();
    logic [W-1:0] v;
    logic [31:0]  t;
    for (int i = 0; i < LANES; i++) begin
      t = $urandom;
      v[i*N +: N] = t[N-1:0];
    end
    return v;
  endfunction

  function automatic logic [W-1:0] lane_vec(input longint mul, input longint add);
    logic [W-1:0] v;
    longint       t;
    for (int i = 0; i < LANES; i++) begin
      t = mul * i + add;
      v[i*N +: N] = t[N-1:0];
    end
    return v;
  endfunction

  // Monitor: compare on handshake, check that held output stays stable.
  always @(negedge clk) begin
    if (RST || !out_valid) begin
      prev_hold = 1'b0;
    end else begin
      ov_count++;
      if (prev_hold) check("hold_result", result, prev_res);
      if (out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got result %h expected no output", result);
        end else begin
          mon_e = sb.pop_front();
          check("result", result, mon_e.res);
          check("wa3_out", W'(wa3_out), W'(mon_e.wa3));
          check("RegWrite_out", W'(RegWrite_out), W'(mon_e.rw));
`ifdef VEXEC_SAT_EN
          check("sat_flag", W'(sat_flag), W'(mon_e.sat));
`endif
        end
        prev_hold = 1'b0;
      end else begin
        prev_hold = 1'b1;
        prev_res  = result;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Returns just after the accepting edge; operand inputs are scrambled afterwards.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] imm,
                       input logic src, input logic [2:0] op, input logic [3:0] wa, input logic rw);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready %b expected 1", in_ready);
    end else begin
      rd1 = a; rd2 = b; ExtImm = imm; ALUSrc = src; ALUControl = op;
      wa3 = wa; RegWrite = rw; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rd1 = rnd_vec(); rd2 = rnd_vec(); ExtImm = rnd_vec();
      sb.push_back(model(a, b, imm, src, op, wa, rw));
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic issue_random();
    logic [31:0] r;
    r = $urandom;
    issue(rnd_vec(), rnd_vec(), rnd_vec(), r[0], r[3:1], r[7:4], r[8]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t;
    int snap;
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    rd1 = '0; rd2 = '0; ExtImm = '0; ALUSrc = 1'b0; ALUControl = '0;
    wa3 = '0; RegWrite = 1'b0;
    repeat (3) @(posedge clk);
    #1 RST = 1'b0;

    @(negedge clk);
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_result", result, '0);
    check("rst_busy", W'(busy), W'(0));
    check("rst_regwrite", W'(RegWrite_out), W'(0));

    // ADD with latency and return-to-idle checks
    issue(lane_vec(1, 0), lane_vec(0, 100), '0, 1'b0, 3'd0, 4'd5, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("latency_low", W'(out_valid), W'(0));
    end
    @(negedge clk);
    check("latency_high", W'(out_valid), W'(1));
    @(negedge clk);
    check("idle_after_add", W'(in_ready), W'(1));

    issue(lane_vec(0, 0), lane_vec(0, 1), '0, 1'b0, 3'd1, 4'd2, 1'b1);
    issue(lane_vec(0, 20'h7FFFF), lane_vec(0, 1), '0, 1'b0, 3'd0, 4'd3, 1'b0);
    issue(lane_vec(0, 3), rnd_vec(), lane_vec(0, 4), 1'b1, 3'd5, 4'd7, 1'b1);
    issue(rnd_vec(), rnd_vec(), lane_vec(3, 0), 1'b1, 3'd7, 4'd9, 1'b1);
    issue(lane_vec(0, 20'h80000), lane_vec(0, 15), '0, 1'b0, 3'd6, 4'd1, 1'b1);
    wait_drain();

    // Backpressure: hold DONE for 5 cycles while an ignored op is offered
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue_random();
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("bp_reached_done", W'(out_valid), W'(1));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1; rd1 = rnd_vec(); ALUControl = 3'd4;
      @(negedge clk);
      check("bp_out_valid", W'(out_valid), W'(1));
      check("bp_in_ready", W'(in_ready), W'(0));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    issue_random();
    wait_drain();

    // Flush on the second RUN cycle
    issue(rnd_vec(), rnd_vec(), rnd_vec(), 1'b0, 3'd0, 4'd6, 1'b1);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    check("flush_busy", W'(busy), W'(0));
    check("flush_in_ready", W'(in_ready), W'(1));
    check("flush_regwrite", W'(RegWrite_out), W'(0));
    snap = ov_count;
    repeat (8) @(negedge clk);
    check("flush_no_pulse", W'(ov_count), W'(snap));

    // flush beats in_valid in IDLE
    in_valid = 1'b1; flush = 1'b1; rd1 = rnd_vec();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("flush_wins_idle", W'(busy), W'(0));

    // Asynchronous reset mid-RUN, then a clean op
    issue(lane_vec(5, 7), lane_vec(1, 1), '0, 1'b0, 3'd3, 4'd12, 1'b1);
    @(posedge clk);
    @(negedge clk);
    #1 RST = 1'b1;
    #1;
    check("arst_out_valid", W'(out_valid), W'(0));
    check("arst_result", result, '0);
    check("arst_busy", W'(busy), W'(0));
    check("arst_regwrite", W'(RegWrite_out), W'(0));
    check("arst_wa3", W'(wa3_out), W'(0));
    void'(sb.pop_back());
    @(posedge clk);
    #1 RST = 1'b0;
    issue(lane_vec(2, 9), lane_vec(3, 4), '0, 1'b0, 3'd4, 4'd11, 1'b1);
    wait_drain();

    // Randomized ops under random downstream backpressure
    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) issue_random();
    wait_drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
